// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MDIO management master. Serialises one read or write
// request into an MDC/MDIO frame, then returns read data and a turnaround-error flag.
// Optional build macro: MDIO_MASTER_PREAMBLE_SUPPRESS_EN omits the 32-bit preamble.
module mdio_master #(
  parameter int unsigned CLK_DIV = 10
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phyad,
  input  logic [4:0]  req_regad,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic        mdio_in
);

`ifdef MDIO_MASTER_PREAMBLE_SUPPRESS_EN
  localparam bit HasPre = 1'b0;
`else
  localparam bit HasPre = 1'b1;
`endif

  // Frame positions of the last bit and of the first turnaround bit
  localparam logic [5:0] LastIdx = HasPre ? 6'd63 : 6'd31;
  localparam logic [5:0] TaIdx   = HasPre ? 6'd46 : 6'd14;

  localparam int unsigned     DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StShift, StGap, StDone} state_e;

  state_e          state_q;
  logic [DivW-1:0] div_q;
  logic [5:0]      bit_q;
  logic            write_q;
  logic            gap_half_q;
  logic [31:0]     frame_q;   // ST..DATA, MSB first; preamble is implied by bit index
  logic [16:0]     rd_sh_q;   // second TA bit followed by the 16 data bits

  logic [31:0]     new_frame;
  logic [5:0]      next_bit;
  logic            div_wrap;

  // Read frames drive 1s through TA/DATA so the pad idles high if oe is ignored
  assign new_frame = {2'b01, (req_write ? 2'b01 : 2'b10), req_phyad, req_regad,
                      (req_write ? {2'b10, req_wdata} : 18'h3FFFF)};
  assign next_bit  = bit_q + 6'd1;
  assign div_wrap  = (div_q == DivMax);

  // Bit idx of the frame: preamble ones for idx < 32, otherwise the captured word
  function automatic logic frame_bit(input logic [31:0] f, input logic [5:0] idx);
    return (HasPre && !idx[5]) ? 1'b1 : f[~idx[4:0]];
  endfunction

  // Frame sequencer with registered pad, clock and response outputs
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      bit_q      <= '0;
      write_q    <= 1'b0;
      gap_half_q <= 1'b0;
      frame_q    <= '0;
      rd_sh_q    <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      mdc        <= 1'b0;
      mdio_out   <= 1'b1;
      mdio_oe    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            state_q   <= StShift;
            req_ready <= 1'b0;
            write_q   <= req_write;
            frame_q   <= new_frame;
            rd_sh_q   <= '0;
            bit_q     <= '0;
            div_q     <= '0;
            mdc       <= 1'b0;
            mdio_out  <= frame_bit(new_frame, 6'd0);
            mdio_oe   <= 1'b1;
          end
        end
        StShift: begin
          div_q <= div_wrap ? '0 : div_q + 1'b1;
          if (div_wrap && !mdc) begin
            mdc <= 1'b1;
            // Capture from the second TA bit onward on the rising edge
            if (!write_q && (bit_q > TaIdx)) begin
              rd_sh_q <= {rd_sh_q[15:0], mdio_in};
            end
          end else if (div_wrap) begin
            mdc <= 1'b0;
            if (bit_q == LastIdx) begin
              state_q    <= StGap;
              mdio_oe    <= 1'b0;
              mdio_out   <= 1'b1;
              gap_half_q <= 1'b0;
            end else begin
              bit_q    <= next_bit;
              mdio_out <= frame_bit(frame_q, next_bit);
              mdio_oe  <= write_q || (next_bit < TaIdx);
            end
          end
        end
        StGap: begin
          // One full idle MDC period with mdc held low
          div_q <= div_wrap ? '0 : div_q + 1'b1;
          if (div_wrap) begin
            gap_half_q <= 1'b1;
            if (gap_half_q) begin
              state_q   <= StDone;
              rsp_valid <= 1'b1;
              rsp_err   <= !write_q && rd_sh_q[16];
              if (!write_q) begin
                rsp_rdata <= rd_sh_q[15:0];
              end
            end
          end
        end
        StDone: begin
          state_q   <= StIdle;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: scoreboard bench for mdio_master with a behavioural PHY responder.
module tb_mdio_master;

`ifdef MDIO_MASTER_PREAMBLE_SUPPRESS_EN
  localparam int ClkDiv = 2;
  localparam int PreLen = 0;
`else
  localparam int ClkDiv = 10;
  localparam int PreLen = 32;
`endif
  localparam int NBits = PreLen + 32;
  localparam int TaIdx = PreLen + 14;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [4:0]  req_phyad = '0;
  logic [4:0]  req_regad = '0;
  logic [15:0] req_wdata = '0;
  logic        mdio_in = 1'b1;
  logic        req_ready, rsp_valid, rsp_err, mdc, mdio_out, mdio_oe;
  logic [15:0] rsp_rdata;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    logic        write;
    logic [4:0]  phyad;
    logic [4:0]  regad;
    logic [15:0] wdata;
    logic        present;
    logic [15:0] pdata;
    logic [15:0] rdata;
    logic        err;
    int unsigned t0;
    int unsigned t_done;
  } txn_t;

  txn_t        exp_q[$];
  logic [15:0] last_rdata = '0;
  int unsigned last_t0 = 0;
  int unsigned last_t_done = 0;

  mdio_master #(.CLK_DIV(ClkDiv)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_phyad(req_phyad),
    .req_regad(req_regad),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .mdc      (mdc),
    .mdio_out (mdio_out),
    .mdio_oe  (mdio_oe),
    .mdio_in  (mdio_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected frame, bit k of the frame at vector index k
  function automatic logic [63:0] exp_frame(input txn_t t);
    logic [31:0] w;
    logic [63:0] f;
    w = {2'b01, (t.write ? 2'b01 : 2'b10), t.phyad, t.regad,
         (t.write ? {2'b10, t.wdata} : 18'h0)};
    f = '0;
    for (int k = 0; k < NBits; k++) f[k] = (k < PreLen) ? 1'b1 : w[31 - (k - PreLen)];
    return f;
  endfunction

  function automatic logic [63:0] exp_oe(input txn_t t);
    logic [63:0] f;
    f = '0;
    for (int k = 0; k < NBits; k++) f[k] = t.write || (k < TaIdx);
    return f;
  endfunction

  // PHY answer for frame bit k: TA = z(pulled 1),0 then data; absent PHY reads all 1s
  function automatic logic resp_bit(input txn_t t, input int k);
    if (t.write || !t.present) return 1'b1;
    if (k == TaIdx + 1) return 1'b0;
    if (k >= TaIdx + 2 && k < NBits) return t.pdata[15 - (k - TaIdx - 2)];
    return 1'b1;
  endfunction

  // Monitor and responder: tracks the head transaction, pops and compares on rsp_valid
  initial begin : monitor
    int          rise_cnt;
    logic        mdc_prev;
    logic [63:0] obs_out, obs_oe, mask;
    logic        timing_ok, busy_ok;
    txn_t        h;
    rise_cnt = 0; mdc_prev = 1'b0; obs_out = '0; obs_oe = '0; timing_ok = 1'b1; busy_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        rise_cnt = 0; obs_out = '0; obs_oe = '0; timing_ok = 1'b1; busy_ok = 1'b1;
        mdc_prev = 1'b0; mdio_in = 1'b1;
      end else begin
        if (exp_q.size() != 0 && cyc > exp_q[0].t0) begin
          if (mdc && !mdc_prev) begin
            if (rise_cnt < 64) begin
              obs_out[rise_cnt] = mdio_out;
              obs_oe[rise_cnt]  = mdio_oe;
            end
            if (cyc != exp_q[0].t0 + 1 + (2 * rise_cnt + 1) * ClkDiv) timing_ok = 1'b0;
            rise_cnt++;
          end
          if (cyc <= exp_q[0].t_done && req_ready) busy_ok = 1'b0;
          if (!mdc) mdio_in = resp_bit(exp_q[0], rise_cnt);
        end
        mdc_prev = mdc;
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, expected no response", cyc);
          end else begin
            h = exp_q.pop_front();
            mask = exp_oe(h);
            check("rsp_time", 64'(cyc), 64'(h.t_done));
            check("rsp_rdata", 64'(rsp_rdata), 64'(h.rdata));
            check("rsp_err", 64'(rsp_err), 64'(h.err));
            check("frame_bits", obs_out & mask, exp_frame(h) & mask);
            check("frame_oe", obs_oe, mask);
            check("mdc_rises", 64'(rise_cnt), 64'(NBits));
            check("mdc_timing", 64'(timing_ok), 64'd1);
            check("ready_busy", 64'(busy_ok), 64'd1);
          end
          rise_cnt = 0; obs_out = '0; obs_oe = '0; timing_ok = 1'b1; busy_ok = 1'b1;
          mdio_in = 1'b1;
        end else if (exp_q.size() != 0 && cyc > exp_q[0].t_done + 4) begin
          n_cmp++; n_bad++;
          $display("FAIL rsp_timeout: no rsp_valid by cycle %0d, expected at %0d",
                   cyc, exp_q[0].t_done);
          void'(exp_q.pop_front());
          rise_cnt = 0; obs_out = '0; obs_oe = '0; timing_ok = 1'b1; busy_ok = 1'b1;
        end
      end
    end
  end

  // Present a request from a negedge; push the expected response on acceptance
  task automatic issue(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd, input logic present, input logic [15:0] pd,
                       input bit hold, input bit noise);
    txn_t t;
    int   budget;
    req_write = wr; req_phyad = pa; req_regad = ra; req_wdata = wd; req_valid = 1'b1;
    budget = 4 * (NBits + 2) * ClkDiv + 100;
    while (!req_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: req_ready=%0b, expected 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    t.write = wr; t.phyad = pa; t.regad = ra; t.wdata = wd; t.present = present; t.pdata = pd;
    t.t0 = cyc;
    t.t_done = cyc + 1 + 2 * (NBits + 1) * ClkDiv;
    if (wr) begin
      t.rdata = last_rdata;
      t.err = 1'b0;
    end else begin
      t.rdata = present ? pd : 16'hFFFF;
      t.err = !present;
      last_rdata = t.rdata;
    end
    exp_q.push_back(t);
    last_t0 = t.t0;
    last_t_done = t.t_done;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    if (noise) begin
      for (int i = 0; i < 40; i++) begin
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_phyad = 5'($urandom);
        req_wdata = 16'($urandom);
        @(negedge clk);
      end
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int budget;
    budget = 4 * (NBits + 2) * ClkDiv + 50;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: %0d responses pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 64'({mdc, mdio_out, mdio_oe, req_ready, rsp_valid, rsp_err, rsp_rdata}),
          64'({1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000}));
  endtask

  initial begin : driver
    int unsigned first_done;
    int          rst_bit;
    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    arst_n = 1'b1;
    @(negedge clk);

    // Directed write, present read, absent PHY
    issue(1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, 16'h0, 1'b0, 1'b0);
    wait_idle();
    issue(1'b0, 5'd3, 5'd2, 16'h0, 1'b1, 16'h796D, 1'b0, 1'b0);
    wait_idle();
    issue(1'b0, 5'd5, 5'd7, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    wait_idle();

    // Back-to-back: valid held high across a read then a write
    issue(1'b0, 5'd2, 5'd17, 16'h0, 1'b1, 16'h3C5A, 1'b1, 1'b0);
    first_done = last_t_done;
    issue(1'b1, 5'd2, 5'd17, 16'hBEEF, 1'b0, 16'h0, 1'b0, 1'b0);
    check("b2b_accept", 64'(last_t0), 64'(first_done + 1));
    wait_idle();

    // Valid toggling while busy must not start another frame
    issue(1'b0, 5'd9, 5'd4, 16'h0, 1'b1, 16'h0F0F, 1'b0, 1'b1);
    wait_idle();

    // Reset in the middle of bit 40 (bit 8 of the frame without preamble)
    rst_bit = PreLen + 8;
    issue(1'b0, 5'd4, 5'd9, 16'h0, 1'b1, 16'hA5C3, 1'b0, 1'b0);
    repeat (2 * rst_bit * ClkDiv + ClkDiv / 2) @(negedge clk);
    #2;
    arst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    last_rdata = '0;
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    repeat (2 * (NBits + 2) * ClkDiv) @(negedge clk);

    // Randomised traffic after the reset
    for (int i = 0; i < 8; i++) begin
      logic wr;
      wr = 1'($urandom_range(0, 1));
      issue(wr, 5'($urandom), 5'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0),
            16'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdio_master.md
# mdio_master

Clause-22 MDIO management master: serialises single register read/write requests into MDC/MDIO frames and returns read data with a turnaround-error flag. It is the DUT-side initiator for the PHY MDIO slave models in the multi-port ethernet bench, one instance per PHY port, driving the top-level tri-state `mdio` pad through `mdio_out`/`mdio_oe`.

## Interface
- `CLK_DIV`, default 10: MDC half-period in `clk` cycles; legal range 2..255.
- `clk`  in  1  system clock
- `arst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  master idle, accepts request
- `req_write`  in  1  1 = write, 0 = read
- `req_phyad`  in  5  PHY address
- `req_regad`  in  5  register address
- `req_wdata`  in  16  write data
- `rsp_valid`  out  1  one-cycle completion pulse, for reads and writes
- `rsp_rdata`  out  16  read data; held until the next read completes
- `rsp_err`  out  1  read turnaround error; held until the next completion
- `mdc`  out  1  management clock
- `mdio_out`  out  1  serial data to pad
- `mdio_oe`  out  1  pad output enable
- `mdio_in`  in  1  pad input

## Operation
- Request is accepted on `req_valid && req_ready`. All request fields are captured at acceptance; `req_ready` drops on the following cycle.
- While busy, `req_valid` is ignored.
- Frame bits, MSB first per field:
  - preamble: 32 × 1
  - ST: 01
  - OP: 01 for write, 10 for read
  - PHYAD[4:0], REGAD[4:0]
  - TA
  - DATA[15:0]
- Bit indices with preamble: 0–31 preamble, 32–33 ST, 34–35 OP, 36–40 PHYAD, 41–45 REGAD, 46–47 TA, 48–63 DATA.
- Write frame:
  - TA is driven as 10.
  - `mdio_oe` is 1 for all 64 bits.
- Read frame:
  - `mdio_oe` is 0 from TA bit 46 to the end of the frame.
  - `mdio_in` is sampled on the MDC rising edge of bit 47 and bits 48–63.
  - `rsp_err` is set if bit 47 is not 0. Data is still captured when `rsp_err` is set.
- After the last bit:
  - `mdio_oe` goes to 0 and `mdio_out` to 1.
  - One idle MDC period follows with `mdc` low.
  - Then `rsp_valid` pulses and `req_ready` rises.
- FSM states and transitions:
  - IDLE → (accept) → SHIFT
  - SHIFT → (last bit done) → GAP
  - GAP → (one idle period done) → DONE
  - DONE → (1 cycle) → IDLE
- Counters:
  - Divider counter: `$clog2(CLK_DIV)` bits, wraps at `CLK_DIV-1`.
  - Bit counter: 6 bits.
- Reset values: `mdc`=0, `mdio_out`=1, `mdio_oe`=0, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, FSM=IDLE.
- Reset asserted mid-frame abandons the frame immediately; no `rsp_valid` is produced for it.

## Timing
- Acceptance cycle is T0.
- Bit k is presented on `mdio_out`/`mdio_oe` at T0+1+2k·CLK_DIV.
- `mdc` rises at T0+1+(2k+1)·CLK_DIV and falls at T0+1+(2k+2)·CLK_DIV.
- Data changes only on the cycle `mdc` falls, or at bit 0. This gives CLK_DIV cycles of setup and hold.
- `mdio_in` is registered on the cycle `mdc` goes 1.
- With N frame bits:
  - GAP starts at T0+1+2N·CLK_DIV.
  - `rsp_valid` is high at T0+1+2(N+1)·CLK_DIV.
  - `req_ready` is 1 on the next cycle.
- With preamble, N = 64: completion at T0+1+130·CLK_DIV.
- Back-to-back requests: the earliest next acceptance is the cycle after `rsp_valid`.
- `rsp_rdata` and `rsp_err` update on the same cycle as `rsp_valid`. For writes, `rsp_err`=0 and `rsp_rdata` is unchanged.

## Configuration
- `MDIO_MASTER_PREAMBLE_SUPPRESS_EN`
  - Defined: the 32-bit preamble is omitted. N = 32, and all bit indices above shift down by 32 (TA = 14–15, DATA = 16–31). Completion at T0+1+66·CLK_DIV.
  - Undefined: the full 32-bit preamble is sent; default behaviour.

## Test plan
- **Write:** CLK_DIV=10, write PHYAD=1, REGAD=0, data 0x1140.
  - Bits 32–63 sampled at `mdc` rising edges are 01 01 00001 00000 10 0001000101000000.
  - Bits 0–31 are all 1.
  - `mdio_oe`=1 throughout.
  - `rsp_valid` at T0+1301, `rsp_err`=0.
- **Read:** PHYAD=3, REGAD=2, responder drives TA=z0 and data 0x796D.
  - `mdio_oe` falls at bit 46.
  - `rsp_rdata`=0x796D, `rsp_err`=0.
- **Absent PHY:** read with `mdio_in` held 1.
  - `rsp_rdata`=0xFFFF, `rsp_err`=1, `rsp_valid` still pulses.
- **Back-to-back:** `req_valid` held high with a read then a write.
  - Second acceptance on the cycle after the first `rsp_valid`.
  - `req_valid` toggling while busy causes no acceptance.
- **Reset mid-frame:** assert `arst_n`=0 at bit 40.
  - All outputs take reset values asynchronously in the same cycle.
  - No `rsp_valid`.
  - Next request produces a complete, correct frame.
- **Minimum divider with macro:** CLK_DIV=2 with `MDIO_MASTER_PREAMBLE_SUPPRESS_EN`.
  - MDC period is 4 cycles, first bit is ST=0.
  - `rsp_valid` at T0+133.
